parking_session_ctrl: RTL and testbench

PARKING_SESSION_CTRL -- requirements
Module: parking_session_ctrl

---
 rtl/parking_pkg.sv | 31 +++
 rtl/parking_session_ctrl_sat_counter.sv | 32 +++
 rtl/parking_session_ctrl.sv | 112 +++++++++++
 tb/tb_parking_session_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared encodings, widths and helpers for the parking session controller.
package parking_pkg;

  localparam int SEC_W  = 12;
  localparam int COST_W = 14;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 12'd4095;
  localparam logic [COST_W-1:0] COST_MAX = 14'd16383;

  // Session FSM encoding; codes 5-7 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_QUOTE = 3'd2,
    ST_PAY   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Adds a coin to the running total, clamping at COST_MAX.
  function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                input logic [7:0]        b);
    logic [COST_W:0] sum;
    sum = {1'b0, a} + {{(COST_W + 1 - 8){1'b0}}, b};
    if (sum > {1'b0, COST_MAX}) begin
      sat_add = COST_MAX;
    end else begin
      sat_add = sum[COST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/parking_session_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// The flag is raised by an enable arriving while the count already sits at MAX.
module sat_counter #(
  parameter int             W   = 12,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         ovf
);

  // Count register and overflow flag; clear takes priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (count == MAX) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_session_ctrl.sv
// Parking session controller: times a session in seconds, latches a quote
// from the external cost converter, accumulates coins and reports change.
// Handshake: every control input (start, stop, tick_1hz, coin_valid, clear)
// is a single-cycle strobe sampled on the rising edge; there is no back-pressure,
// so a strobe that is not applicable in the current state is simply dropped
// (coins dropped this way are flagged on coin_reject).
module parking_session_ctrl
  import parking_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [7:0]        sw,
  input  logic              coin_valid,
  input  logic [7:0]        coin_value,
  input  logic [COST_W-1:0] cost_in,
  output logic [7:0]        cfg_sw,
  output logic [SEC_W-1:0]  sec_count,
  output logic [COST_W-1:0] amount_due,
  output logic [COST_W-1:0] paid,
  output logic [COST_W-1:0] change,
  output logic [2:0]        state,
  output logic              time_ovf,
  output logic              coin_reject
);

  state_t              state_q;
  state_t              state_d;
  logic [COST_W-1:0]   paid_sum;
  logic                start_sess;
  logic                cnt_clr;
  logic                cnt_en;

  assign state      = state_q;
  assign paid_sum   = sat_add(paid, coin_value);
  assign start_sess = !clear && start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_clr    = clear || start_sess;
  // A tick coinciding with stop still counts because RUN is the current state.
  assign cnt_en     = !clear && (state_q == ST_RUN) && tick_1hz;

  // Elapsed-seconds counter; its sticky overflow is the time_ovf flag.
  sat_counter #(
    .W   (SEC_W),
    .MAX (SEC_MAX)
  ) u_sec_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (sec_count),
    .ovf   (time_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (stop)  state_d = ST_QUOTE;
        ST_QUOTE: state_d = (cost_in == '0) ? ST_DONE : ST_PAY;
        ST_PAY:   if (coin_valid && (paid_sum >= amount_due)) state_d = ST_DONE;
        ST_DONE:  if (start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Session datapath: configuration latch, quote, payment and change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sw      <= '0;
      amount_due  <= '0;
      paid        <= '0;
      change      <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_valid && (state_q != ST_PAY);
      if (clear) begin
        amount_due <= '0;
        paid       <= '0;
        change     <= '0;
      end else if (start_sess) begin
        cfg_sw <= sw;
        paid   <= '0;
        change <= '0;
      end else if (state_q == ST_QUOTE) begin
        amount_due <= cost_in;
      end else if ((state_q == ST_PAY) && coin_valid) begin
        paid <= paid_sum;
        if (paid_sum >= amount_due) begin
          change <= paid_sum - amount_due;
        end
      end
    end
  end

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Bench for parking_session_ctrl: literal vector table, directed corner
// sequences and a randomized run against a behavioural session model.
module tb_parking_session_ctrl;
  import parking_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        coin_valid = 1'b0;
  logic [7:0]  sw = 8'd0;
  logic [7:0]  coin_value = 8'd0;
  logic [13:0] cost_in;
  logic [7:0]  cfg_sw;
  logic [11:0] sec_count;
  logic [13:0] amount_due;
  logic [13:0] paid;
  logic [13:0] change;
  logic [2:0]  state;
  logic        time_ovf;
  logic        coin_reject;

  always #5 clk = ~clk;

  parking_session_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .sw          (sw),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .cost_in     (cost_in),
    .cfg_sw      (cfg_sw),
    .sec_count   (sec_count),
    .amount_due  (amount_due),
    .paid        (paid),
    .change      (change),
    .state       (state),
    .time_ovf    (time_ovf),
    .coin_reject (coin_reject)
  );

  // Cost converter: whole started minutes times the hourly rate.
  function automatic int cost_of(input int cfg, input int sec);
    int hr;
    int rate;
    hr   = cfg % 32;
    rate = (hr >= 8 && hr <= 17) ? 2 : 1;
    return ((sec + 59) / 60) * rate;
  endfunction

  assign cost_in = 14'(cost_of(int'(cfg_sw), int'(sec_count)));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // States as plain numbers: 0 idle, 1 timing, 2 quoting, 3 paying, 4 done.
  int m_state, m_cfg, m_sec, m_due, m_paid, m_chg, m_ovf, m_rej;

  task automatic model_reset();
    m_state = 0; m_cfg = 0; m_sec = 0; m_due = 0;
    m_paid = 0; m_chg = 0; m_ovf = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit tk, input bit cl,
                            input bit cv, input int cval, input int swv);
    m_rej = (cv && m_state != 3) ? 1 : 0;
    if (cl) begin
      m_state = 0; m_sec = 0; m_due = 0; m_paid = 0; m_chg = 0; m_ovf = 0;
    end else if (m_state == 0 || m_state == 4) begin
      if (st) begin
        m_cfg = swv; m_sec = 0; m_paid = 0; m_chg = 0; m_ovf = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (tk) begin
        if (m_sec == 4095) m_ovf = 1;
        else m_sec = m_sec + 1;
      end
      if (sp) m_state = 2;
    end else if (m_state == 2) begin
      m_due   = cost_of(m_cfg, m_sec);
      m_state = (m_due == 0) ? 4 : 3;
    end else if (m_state == 3) begin
      if (cv) begin
        m_paid = m_paid + cval;
        if (m_paid > 16383) m_paid = 16383;
        if (m_paid >= m_due) begin
          m_chg   = m_paid - m_due;
          m_state = 4;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("state", 32'(state), m_state);
    chk("cfg_sw", 32'(cfg_sw), m_cfg);
    chk("sec_count", 32'(sec_count), m_sec);
    chk("amount_due", 32'(amount_due), m_due);
    chk("paid", 32'(paid), m_paid);
    chk("change", 32'(change), m_chg);
    chk("time_ovf", 32'(time_ovf), m_ovf);
    chk("coin_reject", 32'(coin_reject), m_rej);
  endtask

  // ---------------- driver tasks ----------------
  // Applies one cycle of strobes, advances the model, samples 1 time unit after the edge.
  task automatic cyc(input bit st, input bit sp, input bit tk, input bit cl, input bit cv,
                     input logic [7:0] cval, input logic [7:0] swv, input bit do_chk);
    start = st; stop = sp; tick_1hz = tk; clear = cl;
    coin_valid = cv; coin_value = cval; sw = swv;
    model_step(st, sp, tk, cl, cv, int'(cval), int'(swv));
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; tick_1hz = 1'b0; clear = 1'b0; coin_valid = 1'b0;
    if (do_chk) check_model();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 8'd0, 8'd0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         st, sp, tk, cl, cv;
    logic [7:0] cval, swv;
    int         e_state, e_sec, e_due, e_paid, e_chg;
    bit         e_rej;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Table: hour 18 (rate 1) session, 2 s -> quote 1, pay 3 -> change 2.
    tbl[0]  = '{1, 0, 0, 0, 0, 8'd0, 8'h12, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 8'd0, 8'h00, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 8'd7, 8'h00, 1, 2, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 0, 8'd0, 8'h00, 2, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 8'd0, 8'h00, 3, 2, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 8'd0, 8'h00, 3, 2, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 8'd0, 8'hFF, 3, 2, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 8'd3, 8'h00, 4, 2, 1, 3, 2, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 8'd0, 8'h00, 4, 2, 1, 3, 2, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 8'd0, 8'h00, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 8'd0, 8'h00, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 8'd0, 8'h00, 0, 0, 0, 0, 0, 0};

    // Reset state while rst_n is held low.
    model_reset();
    #7;
    check_model();
    do_reset();
    idle_cyc();
    idle_cyc();

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].cl, tbl[i].cv, tbl[i].cval, tbl[i].swv, 1);
      chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].e_state);
      chk($sformatf("tbl%0d_sec", i), 32'(sec_count), tbl[i].e_sec);
      chk($sformatf("tbl%0d_due", i), 32'(amount_due), tbl[i].e_due);
      chk($sformatf("tbl%0d_paid", i), 32'(paid), tbl[i].e_paid);
      chk($sformatf("tbl%0d_chg", i), 32'(change), tbl[i].e_chg);
      chk($sformatf("tbl%0d_rej", i), 32'(coin_reject), tbl[i].e_rej);
    end

    // 61 s at a daytime rate: quote 4 two edges after stop, waiting for payment.
    cyc(1, 0, 0, 0, 0, 8'd0, 8'h09, 1);
    for (int i = 0; i < 61; i++) cyc(0, 0, 1, 0, 0, 8'd0, 8'd0, 1);
    cyc(0, 1, 0, 0, 0, 8'd0, 8'd0, 1);
    idle_cyc();
    idle_cyc();
    chk("q_sec", 32'(sec_count), 61);
    chk("q_due", 32'(amount_due), 4);
    chk("q_state", 32'(state), 3);

    // Coins 1 then 5 settle the quote with change 2; a late coin is rejected.
    cyc(0, 0, 0, 0, 1, 8'd1, 8'd0, 1);
    cyc(0, 0, 0, 0, 1, 8'd5, 8'd0, 1);
    chk("pay_paid", 32'(paid), 6);
    chk("pay_state", 32'(state), 4);
    chk("pay_chg", 32'(change), 2);
    cyc(0, 0, 0, 0, 1, 8'd9, 8'd0, 1);
    chk("late_rej", 32'(coin_reject), 1);
    chk("late_paid", 32'(paid), 6);
    idle_cyc();
    chk("late_rej_drop", 32'(coin_reject), 0);

    // Zero-length session: quote 0 skips the payment stage.
    cyc(1, 0, 0, 0, 0, 8'd0, 8'h09, 1);
    cyc(0, 1, 0, 0, 0, 8'd0, 8'd0, 1);
    chk("zero_quote_state", 32'(state), 2);
    idle_cyc();
    chk("zero_done_state", 32'(state), 4);
    chk("zero_due", 32'(amount_due), 0);

    // Stop with a coincident tick at 59 s: the tick counts first.
    cyc(1, 0, 0, 0, 0, 8'd0, 8'h09, 1);
    for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0, 8'd0, 8'd0, 1);
    cyc(0, 1, 1, 0, 0, 8'd0, 8'd0, 1);
    chk("coinc_sec", 32'(sec_count), 60);
    idle_cyc();
    chk("coinc_due", 32'(amount_due), 2);

    // Clear while paying returns to idle with the payment dropped.
    cyc(0, 0, 0, 0, 1, 8'd1, 8'd0, 1);
    chk("pre_clr_paid", 32'(paid), 1);
    cyc(0, 0, 0, 1, 0, 8'd0, 8'd0, 1);
    chk("clr_state", 32'(state), 0);
    chk("clr_paid", 32'(paid), 0);

    // Saturation of the seconds counter.
    cyc(1, 0, 0, 0, 0, 8'd0, 8'h09, 1);
    for (int i = 0; i < 4100; i++) cyc(0, 0, 1, 0, 0, 8'd0, 8'd0, 0);
    check_model();
    chk("sat_sec", 32'(sec_count), 4095);
    chk("sat_ovf", 32'(time_ovf), 1);
    cyc(0, 1, 0, 0, 0, 8'd0, 8'd0, 1);
    idle_cyc();
    chk("sat_due", 32'(amount_due), 138);

    // Asynchronous reset in the middle of a payment.
    cyc(0, 0, 0, 0, 1, 8'd10, 8'd0, 1);
    chk("pre_rst_paid", 32'(paid), 10);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    do_reset();
    idle_cyc();

    // Randomized sessions against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
          8'($urandom_range(0, 40)), 8'($urandom), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
